xgmii_tx_arbiter: RTL and testbench

- Shares the single 72-bit XGMII-TX FIFO write port between two frame sources.
  - Requester 0: the PCIe RX snoop path.
  - Requester 1: the local ARP/control responder.
- Sources present pre-encoded XGMII words: {ctrl[7:0], data[63:0]}.
- Grants whole frames round-robin, inserts a minimum inter-frame gap of idle words, and keeps the FIFO fed with idle words whenever no frame is in flight.

---
 rtl/xgmii_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 19 +
 rtl/xgmii_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_xgmii_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared types and constants for the XGMII-TX FIFO arbiter.
//   XGMII_W        : width of one pre-encoded XGMII word {ctrl[7:0], data[63:0]}
//   XGMII_IDLE     : idle word (all lanes control, /I/ in every byte)
//   XGMII_CTRL_*   : control characters used on the lanes
//   xgmii_word_t   : packed view of one XGMII word
//   arb_state_e    : arbiter states
package xgmii_pkg;

  localparam int unsigned XGMII_CTRL_W = 8;
  localparam int unsigned XGMII_DATA_W = 64;
  localparam int unsigned XGMII_W      = XGMII_CTRL_W + XGMII_DATA_W;

  localparam logic [7:0] XGMII_CTRL_START = 8'hfb;
  localparam logic [7:0] XGMII_CTRL_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_CTRL_IDLE  = 8'h07;

  localparam logic [XGMII_W-1:0] XGMII_IDLE = {8'hff, {8{XGMII_CTRL_IDLE}}};

  typedef struct packed {
    logic [XGMII_CTRL_W-1:0] ctrl;
    logic [XGMII_DATA_W-1:0] data;
  } xgmii_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_IFG  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   valid_i  : request lines, bit N = requester N
//   rr_ptr_i : requester preferred when both request
//   winner_o : one-hot winner, 00 when nobody requests
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] winner_o
);

  // A tie goes to the pointer; a single request always wins.
  always_comb begin
    winner_o = valid_i;
    if (valid_i == 2'b11) begin
      winner_o = rr_ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// Whole-frame round-robin arbiter sharing one XGMII-TX FIFO write port
// between the PCIe RX snoop path (requester 0) and the ARP/control
// responder (requester 1). Inserts IFG_WORDS idle words after each frame
// and keeps the FIFO fed with idles whenever no frame is in flight.
//
// Ports:
//   clk, sys_rst              : clock, synchronous active-high reset
//   reqN_data/valid/last      : requester N word, valid, end-of-frame
//   reqN_ready                : requester N word accepted (combinational)
//   din, wr_en                : registered FIFO write data / enable
//   full                      : FIFO full
//   grant                     : one-hot current owner, 00 when none
// Optional (macro XGMII_TX_ARB_STATS_EN):
//   frames0, frames1          : frames completed per requester (wrapping)
//   gap_stalls                : source-underrun cycles mid-frame (saturating)
module xgmii_tx_arbiter
  import xgmii_pkg::*;
#(
  parameter int unsigned         IFG_WORDS = 1,
  parameter logic [XGMII_W-1:0]  IDLE_WORD = XGMII_IDLE
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic [XGMII_W-1:0] req0_data,
  input  logic               req0_valid,
  input  logic               req0_last,
  output logic               req0_ready,
  input  logic [XGMII_W-1:0] req1_data,
  input  logic               req1_valid,
  input  logic               req1_last,
  output logic               req1_ready,
  output logic [XGMII_W-1:0] din,
  input  logic               full,
  output logic               wr_en,
  output logic [1:0]         grant
`ifdef XGMII_TX_ARB_STATS_EN
  ,
  output logic [31:0]        frames0,
  output logic [31:0]        frames1,
  output logic [15:0]        gap_stalls
`endif
);

  localparam int unsigned IFG_CNT_W = 4;

  arb_state_e          state_q;
  logic [1:0]          grant_q;
  logic                rr_ptr_q;
  logic [IFG_CNT_W-1:0] ifg_cnt_q;
  logic [XGMII_W-1:0]  din_q;
  logic                wr_en_q;

  logic [1:0]          winner;
  xgmii_word_t         sel_word;
  logic                sel_valid;
  logic                sel_last;
  logic                accept;
  logic                ifg_done;

  rr_arb2 u_rr_arb2 (
    .valid_i  ({req1_valid, req0_valid}),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner)
  );

  // Only the granted requester sees ready, and only while the FIFO has room.
  assign req0_ready = (state_q == ST_XFER) & grant_q[0] & ~full;
  assign req1_ready = (state_q == ST_XFER) & grant_q[1] & ~full;

  // Mux of the granted requester's handshake.
  assign sel_word  = grant_q[1] ? req1_data  : req0_data;
  assign sel_valid = grant_q[1] ? req1_valid : req0_valid;
  assign sel_last  = grant_q[1] ? req1_last  : req0_last;
  assign accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // The idle being written this cycle is the last one owed for the gap.
  assign ifg_done  = (ifg_cnt_q + IFG_CNT_W'(1)) == IFG_CNT_W'(IFG_WORDS);

  // Arbiter FSM with registered FIFO write port.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_ptr_q  <= 1'b0;
      ifg_cnt_q <= '0;
      din_q     <= IDLE_WORD;
      wr_en_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q <= ~full;
          if (!full) begin
            din_q <= IDLE_WORD;
          end
          // Arbitration does not wait for FIFO room.
          if (|winner) begin
            grant_q <= winner;
            state_q <= ST_XFER;
          end
        end

        ST_XFER: begin
          // No idles mid-frame: an underrun or full simply skips the write.
          wr_en_q <= accept;
          if (accept) begin
            din_q <= sel_word;
            if (sel_last) begin
              // Point at the other requester so frames alternate.
              rr_ptr_q  <= grant_q[0];
              grant_q   <= 2'b00;
              ifg_cnt_q <= '0;
              state_q   <= ST_IFG;
            end
          end
        end

        ST_IFG: begin
          wr_en_q <= ~full;
          if (!full) begin
            din_q     <= IDLE_WORD;
            ifg_cnt_q <= ifg_cnt_q + IFG_CNT_W'(1);
            if (ifg_done) begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign din   = din_q;
  assign wr_en = wr_en_q;
  assign grant = grant_q;

`ifdef XGMII_TX_ARB_STATS_EN
  logic [31:0] frames0_q;
  logic [31:0] frames1_q;
  logic [15:0] gap_stalls_q;

  // Per-requester frame counters and mid-frame underrun counter.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      frames0_q    <= '0;
      frames1_q    <= '0;
      gap_stalls_q <= '0;
    end else begin
      if (accept && sel_last && grant_q[0]) begin
        frames0_q <= frames0_q + 32'd1;
      end
      if (accept && sel_last && grant_q[1]) begin
        frames1_q <= frames1_q + 32'd1;
      end
      if ((state_q == ST_XFER) && !full && !sel_valid && (gap_stalls_q != 16'hffff)) begin
        gap_stalls_q <= gap_stalls_q + 16'd1;
      end
    end
  end

  assign frames0    = frames0_q;
  assign frames1    = frames1_q;
  assign gap_stalls = gap_stalls_q;
`else
  // sel_valid only feeds the underrun counter.
  logic unused_sel_valid;
  assign unused_sel_valid = sel_valid;
`endif

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Randomized self-checking bench for xgmii_tx_arbiter with a frame-level
// reference model (owner / owed-gap-idles bookkeeping) and directed phases.
module tb_xgmii_tx_arbiter;

  localparam int unsigned IFG    = 3;
  localparam logic [71:0] IDLE_W = {8'hff, 64'h0707070707070707};
  localparam int          RING   = 64;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [71:0] req0_data, req1_data;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [71:0] din;
  logic        full;
  logic        wr_en;
  logic [1:0]  grant;
`ifdef XGMII_TX_ARB_STATS_EN
  logic [31:0] frames0, frames1;
  logic [15:0] gap_stalls;
`endif

  always #5 clk = ~clk;

  xgmii_tx_arbiter #(.IFG_WORDS(IFG), .IDLE_WORD(IDLE_W)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .din        (din),
    .full       (full),
    .wr_en      (wr_en),
    .grant      (grant)
`ifdef XGMII_TX_ARB_STATS_EN
    ,
    .frames0    (frames0),
    .frames1    (frames1),
    .gap_stalls (gap_stalls)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Sources: ring of pending frame lengths plus position in the head frame.
  int flen [2][RING];
  int f_head [2];
  int f_tail [2];
  int pos [2];

  // Reference model state.
  int          m_owner;   // -1 when nobody owns the port
  int          m_pref;    // requester that wins a tie
  int          m_gap;     // idle writes still owed after a frame
  logic        m_wr;
  logic [71:0] m_din;
`ifdef XGMII_TX_ARB_STATS_EN
  logic [31:0] m_frames [2];
  logic [15:0] m_stalls;
`endif

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] mk_word(input int r, input int f, input int p, input int len);
    logic [7:0] ctrl;
    ctrl = (p == len - 1) ? 8'h80 : 8'h00;
    return {ctrl, 8'(r), 24'(f), 32'(p)};
  endfunction

  function automatic bit has_frame(input int r);
    return f_head[r] != f_tail[r];
  endfunction

  function automatic int cur_len(input int r);
    return flen[r][f_head[r] % RING];
  endfunction

  function automatic logic [1:0] m_grant();
    if (m_owner < 0) return 2'b00;
    return (m_owner == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit busy();
    return has_frame(0) || has_frame(1) || (m_owner >= 0) || (m_gap > 0);
  endfunction

  task automatic push(input int r, input int len);
    flen[r][f_tail[r] % RING] = len;
    f_tail[r]++;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_pref  = 0;
    m_gap   = 0;
    m_wr    = 1'b0;
    m_din   = IDLE_W;
`ifdef XGMII_TX_ARB_STATS_EN
    m_frames[0] = '0;
    m_frames[1] = '0;
    m_stalls    = '0;
`endif
  endtask

  // One clock: check registered outputs, drive inputs, check readies,
  // clock, then advance model and sources.
  task automatic run_cycle(input bit rst, input bit fl, input bit st0, input bit st1);
    bit          vv [2];
    bit          ll [2];
    logic [71:0] dd [2];
    bit          acc [2];
    bit          m_acc;
    @(negedge clk);
    chk("wr_en", 72'(wr_en), 72'(m_wr));
    chk("din", din, m_din);
    chk("grant", 72'(grant), 72'(m_grant()));
`ifdef XGMII_TX_ARB_STATS_EN
    chk("frames0", 72'(frames0), 72'(m_frames[0]));
    chk("frames1", 72'(frames1), 72'(m_frames[1]));
    chk("gap_stalls", 72'(gap_stalls), 72'(m_stalls));
`endif
    for (int r = 0; r < 2; r++) begin
      vv[r] = has_frame(r) && !((r == 0) ? st0 : st1);
      ll[r] = has_frame(r) && (pos[r] == cur_len(r) - 1);
      dd[r] = has_frame(r) ? mk_word(r, f_head[r], pos[r], cur_len(r)) : 72'h0;
    end
    sys_rst    = rst;
    full       = fl;
    req0_valid = vv[0];
    req0_last  = ll[0];
    req0_data  = dd[0];
    req1_valid = vv[1];
    req1_last  = ll[1];
    req1_data  = dd[1];
    #1;
    chk("ready0", 72'(req0_ready), 72'(m_owner == 0 && !fl));
    chk("ready1", 72'(req1_ready), 72'(m_owner == 1 && !fl));
    acc[0] = req0_valid && req0_ready;
    acc[1] = req1_valid && req1_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      m_acc = vv[m_owner] && !fl;
      m_wr  = m_acc;
      if (m_acc) m_din = dd[m_owner];
`ifdef XGMII_TX_ARB_STATS_EN
      if (!fl && !vv[m_owner] && m_stalls != 16'hffff) m_stalls = m_stalls + 16'd1;
      if (m_acc && ll[m_owner]) m_frames[m_owner] = m_frames[m_owner] + 32'd1;
`endif
      if (m_acc && ll[m_owner]) begin
        m_pref  = 1 - m_owner;
        m_owner = -1;
        m_gap   = IFG;
      end
    end else begin
      m_wr = !fl;
      if (!fl) m_din = IDLE_W;
      if (m_gap > 0) begin
        if (!fl) m_gap--;
      end else if (vv[0] || vv[1]) begin
        m_owner = (vv[0] && vv[1]) ? m_pref : (vv[0] ? 0 : 1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        pos[r] = 0;
      end else if (acc[r]) begin
        if (ll[r]) begin
          pos[r] = 0;
          f_head[r]++;
        end else begin
          pos[r]++;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy()) break;
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk(tag, 72'(busy()), 72'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g_seq [$];
    logic [1:0]  prev_g;
    int          fc;
    int          idles;
    bit          counting;
    int          fid;

    for (int r = 0; r < 2; r++) begin
      f_head[r] = 0;
      f_tail[r] = 0;
      pos[r]    = 0;
    end
    model_reset();
    sys_rst = 1'b1; full = 1'b0;
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = '0;

    // Reset, then idle with no requests.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Single 4-word frame from requester 0: first word two cycles after valid.
    fid = f_tail[0];
    push(0, 4);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lat_wr_en", 72'(wr_en), 72'(1));
    chk("lat_din", din, mk_word(0, fid, 0, 4));
    drain("drain_single", 40);

    // Both requesters continuously valid: frames alternate 01,10,01,10.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    push(0, 3); push(0, 3); push(1, 3); push(1, 3);
    prev_g = 2'b00;
    for (int i = 0; i < 80 && busy(); i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (grant != 2'b00 && grant != prev_g) g_seq.push_back(grant);
      prev_g = grant;
    end
    chk("rr_count", 72'(g_seq.size()), 72'(4));
    while (g_seq.size() < 4) g_seq.push_back(2'b00);
    chk("rr_g0", 72'(g_seq[0]), 72'(2'b01));
    chk("rr_g1", 72'(g_seq[1]), 72'(2'b10));
    chk("rr_g2", 72'(g_seq[2]), 72'(2'b01));
    chk("rr_g3", 72'(g_seq[3]), 72'(2'b10));
    drain("drain_rr", 20);

    // FIFO full for three cycles while word 2 is pending.
    push(0, 6);
    fc = 0;
    for (int i = 0; i < 60 && busy(); i++) begin
      bit fl;
      fl = (pos[0] == 2) && (m_owner == 0) && (fc < 3);
      if (fl) fc++;
      run_cycle(1'b0, fl, 1'b0, 1'b0);
    end
    chk("full_cycles", 72'(fc), 72'(3));
    chk("drain_full", 72'(busy()), 72'(0));

    // Full pulsed during the gap: only written idles count toward it. The gap
    // is the IFG idles plus the one written on the arbitration cycle.
    push(0, 2); push(1, 2);
    idles = 0; counting = 1'b0;
    for (int i = 0; i < 60 && busy(); i++) begin
      run_cycle(1'b0, (m_gap > 0) && ($urandom_range(1, 0) == 1), 1'b0, 1'b0);
      #1;
      if (wr_en) begin
        if (din == IDLE_W) begin
          if (counting) idles++;
        end else begin
          if (counting) begin
            chk("ifg_idles", 72'(idles), 72'(IFG + 1));
            counting = 1'b0;
          end
          if (din[71:64] == 8'h80) begin
            counting = 1'b1;
            idles = 0;
          end
        end
      end
    end
    chk("drain_ifg", 72'(busy()), 72'(0));

    // Reset at word 2 of a 5-word requester-1 frame; re-sent with req0 also
    // pending, requester 0 must win after reset.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    push(1, 5);
    for (int i = 0; i < 20 && pos[1] != 2; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reached_word2", 72'(pos[1]), 72'(2));
    push(0, 3);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_wr_en", 72'(wr_en), 72'(0));
    chk("rst_grant", 72'(grant), 72'(2'b00));
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_winner", 72'(grant), 72'(2'b01));
    drain("drain_rst", 60);

    // Random traffic: frame lengths, underruns, full and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        if ((f_tail[r] - f_head[r]) < 2 && $urandom_range(3, 0) == 0) push(r, int'($urandom_range(6, 1)));
      end
      run_cycle($urandom_range(499, 0) == 0, $urandom_range(3, 0) == 0,
                $urandom_range(4, 0) == 0, $urandom_range(4, 0) == 0);
    end
    drain("drain_random", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
